// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle: hazard detection inputs in, stall/flush controls out.
// mem_req/mem_ready handshake: an access is live while mem_req=1 and completes in the cycle mem_ready=1.
interface hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        idex_mem_read;
  logic [4:0]  idex_rt;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        pipe_hold;
  logic        halt_err;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  modport master (
    output id_rs, id_rt, idex_mem_read, idex_rt, branch_taken, mem_req, mem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, halt_err,
           stall_cycles, flush_count
  );

  modport slave (
    input  id_rs, id_rt, idex_mem_read, idex_rt, branch_taken, mem_req, mem_ready,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, halt_err,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze with timeout halt, branch flush, load-use bubble.
// Optional performance counters enabled by defining HAZARD_PERF_EN; state_dbg: 0=RUN, 1=MEM_WAIT, 2=HALT.
module hazard_ctrl #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic             clk,
    input  logic             rst,
    hazard_ctrl_if.slave     hz,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       load_use;
    logic       mem_stall;

    // Register 0 is hardwired, so a load into it can never create a dependency.
    assign load_use = hz.idex_mem_read && (hz.idex_rt != 5'd0) &&
                      ((hz.idex_rt == hz.id_rs) || (hz.idex_rt == hz.id_rt));

    assign mem_stall = ((state == MEM_WAIT) || hz.mem_req) && !hz.mem_ready;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        hz.pc_write    = 1'b1;
        hz.ifid_write  = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_bubble = 1'b0;
        hz.pipe_hold   = 1'b0;
        hz.halt_err    = 1'b0;
        if (rst) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_bubble = 1'b1;
            state_nxt      = RUN;
            wait_cnt_nxt   = 8'd0;
        end else begin
            case (state)
                HALT: begin
                    hz.pc_write   = 1'b0;
                    hz.ifid_write = 1'b0;
                    hz.pipe_hold  = 1'b1;
                    hz.halt_err   = 1'b1;
                end
                RUN, MEM_WAIT: begin
                    if (mem_stall) begin
                        hz.pc_write   = 1'b0;
                        hz.ifid_write = 1'b0;
                        hz.pipe_hold  = 1'b1;
                        if (state == RUN) begin
                            state_nxt    = MEM_WAIT;
                            wait_cnt_nxt = 8'd0;
                        end else begin
                            if (wait_cnt != 8'hFF) wait_cnt_nxt = wait_cnt + 8'd1;
                            if (wait_cnt == WAIT_LAST) state_nxt = HALT;
                        end
                    end else if (hz.branch_taken) begin
                        // Flush also squashes any load-use candidate in ID, so no extra bubble.
                        hz.ifid_flush  = 1'b1;
                        hz.idex_bubble = 1'b1;
                        state_nxt      = RUN;
                    end else if (load_use) begin
                        hz.pc_write    = 1'b0;
                        hz.ifid_write  = 1'b0;
                        hz.idex_bubble = 1'b1;
                        state_nxt      = RUN;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q;
    logic [15:0] flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'd0;
            flush_q <= 16'd0;
        end else begin
            if (!hz.pc_write && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
            if (hz.ifid_flush && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
        end
    end

    assign hz.stall_cycles = stall_q;
    assign hz.flush_count  = flush_q;
`else
    assign hz.stall_cycles = 32'd0;
    assign hz.flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl (WAIT_LIMIT=4): directed scenarios then random traffic against a rule-level model.
module tb_hazard_ctrl;
  localparam int unsigned LIMIT = 4;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  hazard_ctrl_if hz();

  hazard_ctrl #(.WAIT_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .hz        (hz),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: what the pipeline situation is, not how the FSM encodes it
  bit          m_halted;
  bit          m_waiting;
  int unsigned m_wait_seen;
  longint      m_stall;
  int          m_flush;
  logic [5:0]  exp_q[$];
  int          n_pass;
  int          n_total;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, halt_err}
  function automatic logic [5:0] model_out(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                           input logic mr, input logic [4:0] irt, input logic br,
                                           input logic mq, input logic my);
    bit hazard;
    hazard = mr && (irt != 0) && (irt == rs || irt == rt);
    if (r)                                   return 6'b000100;
    if (m_halted)                            return 6'b000011;
    if ((m_waiting || mq) && !my)            return 6'b000010;
    if (br)                                  return 6'b111100;
    if (hazard)                              return 6'b000100;
    return 6'b110000;
  endfunction

  task automatic model_update(input logic r, input logic mq, input logic my, input logic [5:0] e);
    if (r) begin
      m_halted = 0; m_waiting = 0; m_wait_seen = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e[5] && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (e[3] && m_flush < 65535) m_flush++;
      if (m_halted) begin
      end else if (m_waiting) begin
        if (!my) begin
          m_wait_seen++;
          if (m_wait_seen == LIMIT) begin m_halted = 1; m_waiting = 0; end
        end else m_waiting = 0;
      end else if (mq && !my) begin
        m_waiting = 1; m_wait_seen = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver: apply one cycle of inputs, compare mid-cycle, advance model at the edge
  task automatic step(input string tag, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic mr, input logic [4:0] irt, input logic br,
                      input logic mq, input logic my);
    logic [5:0] e;
    @(negedge clk);
    rst = r; hz.id_rs = rs; hz.id_rt = rt; hz.idex_mem_read = mr; hz.idex_rt = irt;
    hz.branch_taken = br; hz.mem_req = mq; hz.mem_ready = my;
    #1;
    e = model_out(r, rs, rt, mr, irt, br, mq, my);
    exp_q.push_back(e);
    check({tag, "/ctl"}, 32'({hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble,
                              hz.pipe_hold, hz.halt_err}), 32'(exp_q.pop_front()));
    check({tag, "/stall"}, hz.stall_cycles, PERF ? 32'(m_stall) : 32'd0);
    check({tag, "/flush"}, 32'(hz.flush_count), PERF ? 32'(m_flush) : 32'd0);
    check({tag, "/state"}, 32'(state_dbg), m_halted ? 32'd2 : (m_waiting ? 32'd1 : 32'd0));
    @(posedge clk);
    model_update(r, mq, my, e);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    m_halted = 0; m_waiting = 0; m_wait_seen = 0; m_stall = 0; m_flush = 0;
    rst = 1'b1; hz.id_rs = 0; hz.id_rt = 0; hz.idex_mem_read = 0; hz.idex_rt = 0;
    hz.branch_taken = 0; hz.mem_req = 0; hz.mem_ready = 1;

    // reset state
    step("rst", 1, 0, 0, 0, 0, 0, 0, 0);
    step("rst", 1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_stall", hz.stall_cycles, 32'd0);

    // load-use, then the dependency clears
    step("lu", 0, 5, 0, 1, 5, 0, 0, 1);
    step("lu_next", 0, 5, 0, 0, 5, 0, 0, 1);
    step("lu_rt", 0, 1, 9, 1, 9, 0, 0, 0);
    // register 0 never stalls
    step("r0", 0, 3, 0, 1, 0, 0, 0, 1);
    #2;
    check("r0_pc", 32'(hz.pc_write), 32'd1);

    // branch beats load-use
    step("br_rst", 1, 0, 0, 0, 0, 0, 0, 1);
    step("br_lu", 0, 7, 0, 1, 7, 1, 0, 1);
    step("br_after", 0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    check("br_flush_count", 32'(hz.flush_count), PERF ? 32'd1 : 32'd0);

    // three-cycle memory wait then release
    step("mw_rst", 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("mw_hold", 0, 0, 0, 0, 0, 0, 1, 0);
    step("mw_rel", 0, 0, 0, 0, 0, 0, 1, 1);
    #2;
    check("mw_stall", hz.stall_cycles, PERF ? 32'd3 : 32'd0);
    check("mw_hold_off", 32'(hz.pipe_hold), 32'd0);

    // timeout into HALT, sticky until reset
    step("to_rst", 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step("to_wait", 0, 0, 0, 0, 0, 0, 1, 0);
    #2;
    check("to_halt_state", 32'(state_dbg), 32'd2);
    step("to_sticky", 0, 2, 2, 1, 2, 1, 1, 1);
    step("to_sticky", 0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    check("to_halt_err", 32'(hz.halt_err), 32'd1);
    step("to_clear", 1, 0, 0, 0, 0, 0, 0, 1);
    #2;
    check("to_clear_err", 32'(hz.halt_err), 32'd0);
    check("to_clear_state", 32'(state_dbg), 32'd0);

    // reset in the second MEM_WAIT cycle
    step("rw_rst", 1, 0, 0, 0, 0, 0, 0, 1);
    step("rw_enter", 0, 0, 0, 0, 0, 0, 1, 0);
    step("rw_wait1", 0, 0, 0, 0, 0, 0, 1, 0);
    step("rw_pulse", 1, 0, 0, 0, 0, 0, 1, 0);
    step("rw_after", 0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    check("rw_state", 32'(state_dbg), 32'd0);
    check("rw_hold", 32'(hz.pipe_hold), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic r;
      r = ($urandom_range(0, 39) == 0) || (m_halted && $urandom_range(0, 3) == 0);
      step("rnd", r, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, default 255, is the maximum number of memory-wait cycles before a halt (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on the posedge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 id_rs  input  5  rs field of the instruction in ID.
REQ-005 id_rt  input  5  rt field of the instruction in ID.
REQ-006 idex_mem_read  input  1  MemRead bit of the ID/EX MEM control field.
REQ-007 idex_rt  input  5  rt destination currently held in ID/EX.
REQ-008 branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-009 mem_req  input  1  data memory access active in MEM this cycle.
REQ-010 mem_ready  input  1  data memory completes the access this cycle.
REQ-011 pc_write  output  1  PC update enable.
REQ-012 ifid_write  output  1  IF/ID load enable.
REQ-013 ifid_flush  output  1  IF/ID clears to NOP.
REQ-014 idex_bubble  output  1  ID/EX loads all-zero WB/MEM/EX control.
REQ-015 pipe_hold  output  1  ID/EX and EX/MEM hold their contents.
REQ-016 halt_err  output  1  sticky memory-timeout flag.
REQ-017 stall_cycles  output  32  count of cycles with pc_write=0.
REQ-018 flush_count  output  16  count of branch flushes.

Function
REQ-019 FSM states RUN, MEM_WAIT, HALT, with a registered state and an 8-bit wait_cnt; outputs are combinational from the state and current inputs.
REQ-020 Evaluation mode (RUN, or MEM_WAIT with mem_ready=1): the block applies the rules below in priority order, and the first match wins.
REQ-021 Rule 1, mem_req=1 and mem_ready=0 -> freeze: pc_write=0, ifid_write=0, pipe_hold=1; next state MEM_WAIT; wait_cnt<=0.
REQ-022 Rule 2, branch_taken=1 -> flush: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1; next state RUN.
REQ-023 Rule 3, load-use (idex_mem_read=1, idex_rt!=0, and idex_rt equals id_rs or id_rt) -> pc_write=0, ifid_write=0, idex_bubble=1; next state RUN; exactly one bubble per hazard.
REQ-024 Otherwise -> pc_write=1, ifid_write=1, all other control outputs 0; next state RUN.
REQ-025 Branch and load-use in the same cycle: the flush wins and no bubble is added for the load-use.
REQ-026 MEM_WAIT with mem_ready=0: freeze outputs as in REQ-021; wait_cnt increments by one.
REQ-027 MEM_WAIT with mem_ready=0 and wait_cnt==WAIT_LIMIT-1: next state HALT.
REQ-028 MEM_WAIT with mem_ready=1: freeze released; the evaluation rules of REQ-020..REQ-024 apply in that same cycle, excluding Rule 1.
REQ-029 HALT: pc_write=0, ifid_write=0, pipe_hold=1, halt_err=1; all inputs ignored; only rst exits.
REQ-030 wait_cnt saturates and never wraps.
REQ-031 Register 0 is never a hazard source.

Reset
REQ-032 rst=1 at a posedge forces: state RUN, wait_cnt 0, and the counters 0.
REQ-033 During a cycle in which rst=1, the outputs SHALL be pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1, pipe_hold=0, halt_err=0.
REQ-034 rst asserted mid-MEM_WAIT or in HALT returns the block to RUN on the next cycle with no residual flags.

Configuration
REQ-035 Macro HAZARD_PERF_EN defined: stall_cycles increments in each non-reset cycle with pc_write=0, saturating at 2^32-1.
REQ-036 Macro HAZARD_PERF_EN defined: flush_count increments on each Rule-2 cycle, saturating at 2^16-1.
REQ-037 Macro HAZARD_PERF_EN undefined: stall_cycles and flush_count remain as ports, tied to 0, with no counter logic.

Verification
REQ-038 Load-use: idex_mem_read=1, idex_rt=5, id_rs=5 for one cycle -> that cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle, with idex_mem_read=0, pc_write=1.
REQ-039 Register-0 case: idex_mem_read=1, idex_rt=0, id_rt=0 -> no stall, pc_write=1.
REQ-040 Branch with load-use: branch_taken=1 with a simultaneous load-use match -> ifid_flush=1, idex_bubble=1, pc_write=1; with HAZARD_PERF_EN, flush_count=1.
REQ-041 Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> pipe_hold=1 for 3 cycles, 0 on the 4th; with HAZARD_PERF_EN, stall_cycles=3.
REQ-042 Timeout: WAIT_LIMIT=4, mem_req=1, mem_ready held 0 -> HALT after 4 MEM_WAIT cycles; halt_err=1 and stays 1 despite mem_ready=1; rst -> halt_err=0, state RUN.
REQ-043 Reset during wait: rst pulsed in the 2nd MEM_WAIT cycle -> next cycle state RUN, pipe_hold=0, counters 0.
